run_ctrl_unit: RTL
==================

// Module: run_ctrl_unit
// PURPOSE
//  Parametrised run-control for the FPGA CPU. Debounces front-panel buttons and runs the
//  mode FSM: ERR=2, PAUSE=4, RUN=5, UART=6. Issues a CPU clock-enable (no derived clock)
//  with programmable 2^s division, single-step and a cycle breakpoint.
//  Counts issued enables in a saturating counter. Sits between board I/O and CPU/UART loader.
// PARAMETERS
//  CNT_W        32       cycle counter width
//  DIV_W        23       max divider exponent; div_sel_i clamped to DIV_W
//  DBNC_CYCLES  100000   clocks a synchronised button must be stable before accepted
// PORTS
//  fpga_clk_i      in   1      system clock (only clock)
//  rst_n_i         in   1      reset, asynchronous, active-low
//  btn_i           in   6      raw buttons {step,uart,continue,pause,err,rst} = [5:0]
//  exc_valid_i     in   1      exc_code_i valid this cycle
//  exc_code_i      in   4      CPU request: 1/3/6 run, 2 err, 4 pause, 5 uart
//  div_sel_i       in   5      divider exponent s; ce every 2^s clocks in RUN
//  clear_cnt_i     in   1      synchronous cycle counter clear
//  bp_en_i         in   1      breakpoint enable
//  bp_cycle_i      in   CNT_W  breakpoint count
//  cpu_ce_o        out  1      CPU clock enable (registered)
//  cpu_rst_o       out  1      one-cycle CPU reset pulse
//  mode_o          out  4      current mode
//  cycle_cnt_o     out  CNT_W  number of ce pulses issued
//  cnt_sat_o       out  1      counter saturated
//  bp_hit_o        out  1      one-cycle pulse on breakpoint stop
// BEHAVIOUR
//  Reset: mode_o=4 (PAUSE); all other outputs and internal counters/syncs 0.
//  Buttons: 2-FF sync; debounce counter reloads on any change.
//   Accepted level after DBNC_CYCLES stable clocks.
//   0->1 of accepted level = one-cycle pulse. Holding a button yields one pulse only.
//  next_mode priority, first match wins; mode_o registers next_mode:
//   1 uart pulse                    -> 6
//   2 rst pulse, mode!=6            -> 5; also cpu_rst_o=1 next cycle, counter cleared
//   3 err pulse, mode!=6            -> 2
//   4 pause pulse, mode==5          -> 4
//   5 continue pulse, mode in{4,6}  -> 5
//   6 exc_valid_i:
//       2, mode!=6                  -> 2
//       4, mode==5                  -> 4
//       1, mode!=6                  -> 5
//       3, mode==4                  -> 5
//       6, mode==6                  -> 5
//       5                           -> 6
//   7 breakpoint: mode==5 & bp_en_i & cycle_cnt_o==bp_cycle_i -> 4; bp_hit_o=1 next cycle
//   8 else hold.
//  Divider: div_cnt forced 0 while mode!=5, increments in RUN.
//   Terminal when (div_cnt & (2^s-1)) == 2^s-1, with s=min(div_sel_i,DIV_W); s=0 always terminal.
//  cpu_ce_o <= (mode==5 & next_mode==5 & terminal & !bp_stop)
//           | (mode==4 & step pulse & no higher-priority event).
//  Hence no ce in any cycle where mode_o!=5, except exactly one per accepted step in PAUSE.
//  Enter RUN at T: s=0 -> ce at T+1,T+2,...; s=2 -> ce at T+4,T+8,...
//  Counter: updated on the edge that sets cpu_ce_o.
//   clear_cnt_i or rst pulse -> 0 and cnt_sat_o=0, overriding increment.
//   Else +1 per ce, holding at all-ones with cnt_sat_o=1; ce continues when saturated.
//  Breakpoint: exactly bp_cycle_i ce pulses are issued, then PAUSE.
//   bp_en_i with cycle_cnt_o already == bp_cycle_i on entering RUN -> zero ce, immediate stop.
//  div_sel_i change mid-RUN: takes effect on the next terminal test, no reset of div_cnt.
//  Reset mid-operation: everything returns to reset values asynchronously; no spurious ce/pulses.
// TESTING  (bench uses DBNC_CYCLES=4, CNT_W=8)
//  1 Out of reset, continue held 6 clk -> mode 4->5.
//     s=0: ce every clock; after 10 clocks cycle_cnt_o=10.
//  2 3-clk glitch on pause -> ignored.
//     Then clean hold -> mode 4; ce low the same cycle mode_o=4.
//  3 PAUSE, step pressed 3 times -> exactly 3 ce pulses, cycle_cnt_o+=3, mode stays 4.
//  4 s=2, bp_en=1, bp_cycle=5, continue -> ce spaced 4 clocks.
//     cnt stops at 5, mode 4, one bp_hit_o pulse.
//  5 s=0 run to 255 -> cnt_sat_o=1, count holds 255, ce continues.
//     clear_cnt_i -> 0, sat cleared.
//  6 exc_code 5 -> mode 6; pause/err ignored, exc 6 -> 5.
//     uart+rst same cycle -> 6.
//     rst_n_i low mid-RUN -> mode 4, outputs 0.

Source files
------------

// File: rtl/run_ctrl_unit.sv
// Run control: button debounce, mode FSM, CPU clock-enable divider,
// single-step, cycle breakpoint and saturating enable counter.
module run_ctrl_unit #(
  parameter int CNT_W       = 32,
  parameter int DIV_W       = 23,
  parameter int DBNC_CYCLES = 100000
) (
  input  logic             fpga_clk_i,
  input  logic             rst_n_i,
  input  logic [5:0]       btn_i,
  input  logic             exc_valid_i,
  input  logic [3:0]       exc_code_i,
  input  logic [4:0]       div_sel_i,
  input  logic             clear_cnt_i,
  input  logic             bp_en_i,
  input  logic [CNT_W-1:0] bp_cycle_i,
  output logic             cpu_ce_o,
  output logic             cpu_rst_o,
  output logic [3:0]       mode_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic             cnt_sat_o,
  output logic             bp_hit_o
);

  typedef enum logic [3:0] {
    M_ERR   = 4'd2,
    M_PAUSE = 4'd4,
    M_RUN   = 4'd5,
    M_UART  = 4'd6
  } mode_e;

  localparam int DB_W = $clog2(DBNC_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DBNC_CYCLES - 1);
  localparam logic [4:0] S_MAX = 5'(DIV_W);

  logic [5:0]      sync1, sync2;
  logic [5:0]      stab, acc, pls;
  logic [DB_W-1:0] db_cnt [6];

  // The cycle in which a new level is seen counts as the first stable clock.
  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1 <= '0;
      sync2 <= '0;
      stab  <= '0;
      acc   <= '0;
      pls   <= '0;
      for (int i = 0; i < 6; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_i;
      sync2 <= sync1;
      for (int i = 0; i < 6; i++) begin
        pls[i] <= 1'b0;
        if (sync2[i] != stab[i]) begin
          stab[i]   <= sync2[i];
          db_cnt[i] <= DB_W'(1);
        end else if (db_cnt[i] != DB_LAST) begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end else begin
          acc[i] <= stab[i];
          pls[i] <= stab[i] & ~acc[i];
        end
      end
    end
  end

  logic rst_p, err_p, pause_p, cont_p, uart_p, step_p;
  assign rst_p   = pls[0];
  assign err_p   = pls[1];
  assign pause_p = pls[2];
  assign cont_p  = pls[3];
  assign uart_p  = pls[4];
  assign step_p  = pls[5];

  mode_e mode_q, mode_d;
  logic  in_run, in_pause, in_uart;
  assign in_run   = (mode_q == M_RUN);
  assign in_pause = (mode_q == M_PAUSE);
  assign in_uart  = (mode_q == M_UART);

  logic [DIV_W-1:0] div_cnt, div_mask;
  logic [4:0]       s_eff;
  logic             term;
  assign s_eff    = (div_sel_i > S_MAX) ? S_MAX : div_sel_i;
  assign div_mask = ~({DIV_W{1'b1}} << s_eff);
  assign term     = ((div_cnt & div_mask) == div_mask);

  logic  exc_hit;
  mode_e exc_mode;
  logic  hit, rst_ev, bp_stop, bp_cond, ce_d;

  assign bp_cond = in_run && bp_en_i && (cycle_cnt_o == bp_cycle_i);

  always_comb begin
    exc_hit  = 1'b0;
    exc_mode = mode_q;
    if (exc_valid_i) begin
      case (exc_code_i)
        4'd2: if (!in_uart)  begin exc_hit = 1'b1; exc_mode = M_ERR;   end
        4'd4: if (in_run)    begin exc_hit = 1'b1; exc_mode = M_PAUSE; end
        4'd1: if (!in_uart)  begin exc_hit = 1'b1; exc_mode = M_RUN;   end
        4'd3: if (in_pause)  begin exc_hit = 1'b1; exc_mode = M_RUN;   end
        4'd6: if (in_uart)   begin exc_hit = 1'b1; exc_mode = M_RUN;   end
        4'd5: begin exc_hit = 1'b1; exc_mode = M_UART; end
        default: ;
      endcase
    end
  end

  // First match wins; any match blocks a step in the same cycle.
  always_comb begin
    mode_d  = mode_q;
    hit     = 1'b1;
    rst_ev  = 1'b0;
    bp_stop = 1'b0;
    if (uart_p) begin
      mode_d = M_UART;
    end else if (rst_p && !in_uart) begin
      mode_d = M_RUN;
      rst_ev = 1'b1;
    end else if (err_p && !in_uart) begin
      mode_d = M_ERR;
    end else if (pause_p && in_run) begin
      mode_d = M_PAUSE;
    end else if (cont_p && (in_pause || in_uart)) begin
      mode_d = M_RUN;
    end else if (exc_hit) begin
      mode_d = exc_mode;
    end else if (bp_cond) begin
      mode_d  = M_PAUSE;
      bp_stop = 1'b1;
    end else begin
      hit = 1'b0;
    end
  end

  assign ce_d = (in_run && (mode_d == M_RUN) && term && !bp_stop)
              | (in_pause && step_p && !hit);

  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mode_q    <= M_PAUSE;
      cpu_ce_o  <= 1'b0;
      cpu_rst_o <= 1'b0;
      bp_hit_o  <= 1'b0;
      div_cnt   <= '0;
    end else begin
      mode_q    <= mode_d;
      cpu_ce_o  <= ce_d;
      cpu_rst_o <= rst_ev;
      bp_hit_o  <= bp_stop;
      div_cnt   <= in_run ? div_cnt + DIV_W'(1) : '0;
    end
  end

  logic [CNT_W-1:0] cnt_nx;
  assign cnt_nx = cycle_cnt_o + CNT_W'(1);

  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cycle_cnt_o <= '0;
      cnt_sat_o   <= 1'b0;
    end else if (clear_cnt_i || rst_ev) begin
      cycle_cnt_o <= '0;
      cnt_sat_o   <= 1'b0;
    end else if (ce_d) begin
      if (&cycle_cnt_o) begin
        cnt_sat_o <= 1'b1;
      end else begin
        cycle_cnt_o <= cnt_nx;
        if (&cnt_nx) cnt_sat_o <= 1'b1;
      end
    end
  end

  assign mode_o = mode_q;

endmodule
